request_deserializer: RTL and testbench
=======================================

Name: request_deserializer

Overview:
Per-solver front end sitting directly downstream of the request distributor: one instance per solver, fed by one bit of the distributor's one-hot valid vector plus the shared data/end-of-stream bus.
- Advertises idleness through `waiting` and captures one word-serial request terminated by end-of-stream.
- Presents the captured request to the solver core as a parallel, valid/ready-handshaked bundle.
- Returns to waiting once the core accepts the bundle.

Parameters:
MAX_WORDS, 8, capacity of the request buffer in 32-bit words (must be ≥ 1).
COUNT_W, $clog2(MAX_WORDS+1), width of the word-count field.
TIMEOUT_CYCLES, 1024, collect-phase watchdog limit (used only with the optional feature).

Ports:
clock  in  1  single clock; all state changes on its rising edge.
reset_n  in  1  synchronous, active-low reset.
in_data  in  32  shared request word bus from the distributor.
in_valid  in  1  this solver's bit of the distributor's one-hot valid vector.
in_end_of_stream  in  1  marks the last word of a request; qualified by in_valid.
waiting  out  1  idle and empty; drives this solver's bit of the distributor's waiting vector.
req_words  out  32*MAX_WORDS  captured words; word k at bits [32k+31:32k].
req_count  out  COUNT_W  number of words stored, 0..MAX_WORDS.
req_overflow  out  1  request exceeded MAX_WORDS; excess words were dropped.
req_valid  out  1  bundle ready for the solver core.
req_ready  in  1  solver core accepts the bundle.
protocol_error  out  1  sticky; a word arrived while the block was in ST_PRESENT.

Behaviour:
- Reset (reset_n=0 at a clock edge) forces:
  - state=ST_IDLE, req_count=0, req_words=0, req_overflow=0, protocol_error=0.
  - Resulting outputs: waiting=1, req_valid=0.
  - Reset mid-collect or mid-present discards the partial or pending request with no handshake.
- States:
  - ST_IDLE: waiting=1. in_valid stores in_data at index 0, sets req_count=1 and clears req_overflow. Next state is ST_PRESENT if in_end_of_stream, else ST_COLLECT.
  - ST_COLLECT: waiting=0. Each in_valid stores at index req_count and increments req_count. If req_count==MAX_WORDS, the word is dropped, req_overflow is set and req_count saturates. in_valid with in_end_of_stream moves to ST_PRESENT.
  - ST_PRESENT: req_valid=1. On req_valid && req_ready, go to ST_IDLE at the next edge; req_words and req_count hold their values (no clear needed). in_valid here drops the word and sets protocol_error (cleared only by reset).
- waiting and req_valid are decoded from the registered state only; there is no combinational path from in_* to waiting.
  - This guarantees waiting is low by the cycle after the end-of-stream word, before the distributor re-enters selection.
- Latency:
  - end-of-stream word sampled at edge t → req_valid=1 from edge t+1.
  - req_ready sampled high at edge u → waiting=1 from edge u+1.
- Single-word request (first word carries end-of-stream): IDLE→PRESENT directly, req_count=1.
- in_end_of_stream without in_valid is ignored. in_data is don't-care when in_valid=0.
- req_words, req_count and req_overflow are stable throughout ST_PRESENT (AXI-style hold until accepted).
- req_ready while not in ST_PRESENT is ignored.

Optional Feature:
REQUEST_DESERIALIZER_TIMEOUT_EN
- Defined:
  - A counter runs in ST_COLLECT and resets on every accepted word.
  - When it reaches TIMEOUT_CYCLES, the partial request is discarded: state→ST_IDLE, req_count=0.
  - Extra output `timeout` (1 bit) pulses high for exactly one cycle.
- Undefined: no counter and no `timeout` port; ST_COLLECT waits indefinitely for end-of-stream.

Decomposition:
- Shared package fractal_pkg:
  - WORD_W=32.
  - Enum request_deser_state_t {ST_IDLE, ST_COLLECT, ST_PRESENT}.
  - Function clog2-safe count width.
- No sub-module. The word store is a register array written by index and is kept inline; the distributor and this block together form a thin pair.

Test Plan:
- Reset with reset_n=0 for 3 cycles, then 1 → waiting=1, req_valid=0, req_count=0, protocol_error=0 on the first cycle after release.
- Send 0x11111111, 0x22222222, 0x33333333 (eos on last), req_ready=0 → req_valid=1 one cycle after the eos word, req_count=3, words 0..2 match, waiting=0. Raise req_ready → waiting=1 next cycle.
- Single word 0xDEADBEEF with eos in ST_IDLE → ST_PRESENT next cycle, req_count=1, req_overflow=0.
- MAX_WORDS=4, send 6 words, eos on the 6th → req_count=4, req_overflow=1, words 0..3 = first four sent.
- Pulse in_valid during ST_PRESENT → word ignored, req_words unchanged, protocol_error=1 and held until reset.
- With REQUEST_DESERIALIZER_TIMEOUT_EN and TIMEOUT_CYCLES=16: send 2 words, then idle 16 cycles → one-cycle timeout pulse, waiting=1, req_count=0; pull reset_n low mid-collect → waiting=1 after the edge with no req_valid.

Source files
------------

// File: rtl/fractal_pkg.sv
// Shared definitions for the request deserializer.
//   WORD_W                 width of one request word
//   request_deser_state_t  deserializer FSM states
//   count_width()          width of a 0..max_words counter, never below 1 bit
package fractal_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PRESENT = 2'd2
    } request_deser_state_t;

    function automatic int count_width(input int max_words);
        int w;
        w = $clog2(max_words + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/request_deserializer.sv
// Per-solver front end behind the request distributor. Captures one
// word-serial request terminated by end-of-stream and presents it to the
// solver core as a parallel bundle with a valid/ready handshake.
//
// Ports:
//   clock            rising-edge clock
//   reset_n          synchronous active-low reset
//   in_data          shared request word bus
//   in_valid         this solver's bit of the one-hot valid vector
//   in_end_of_stream last word of the request (qualified by in_valid)
//   waiting          idle and empty; this solver's bit of the waiting vector
//   timeout          one-cycle pulse when a partial request is abandoned
//                    (only with REQUEST_DESERIALIZER_TIMEOUT_EN)
//   req_words        captured words, word k at [32k+31:32k]
//   req_count        number of stored words, 0..MAX_WORDS
//   req_overflow     request was longer than MAX_WORDS; excess dropped
//   req_valid        bundle available to the solver core
//   req_ready        solver core accepts the bundle
//   protocol_error   sticky: a word arrived while a bundle was presented
//
// Build option: define REQUEST_DESERIALIZER_TIMEOUT_EN to add a collect-phase
// watchdog of TIMEOUT_CYCLES idle cycles and the timeout output.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | empty, waiting=1; first word lands at index 0
// ST_COLLECT | request in progress; words appended until end-of-stream
// ST_PRESENT | bundle held stable with req_valid=1 until req_ready
module request_deserializer
    import fractal_pkg::*;
#(
    parameter int MAX_WORDS      = 8,
    parameter int COUNT_W        = count_width(MAX_WORDS),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [WORD_W-1:0]           in_data,
    input  logic                        in_valid,
    input  logic                        in_end_of_stream,
    output logic                        waiting,
`ifdef REQUEST_DESERIALIZER_TIMEOUT_EN
    output logic                        timeout,
`endif
    output logic [WORD_W*MAX_WORDS-1:0] req_words,
    output logic [COUNT_W-1:0]          req_count,
    output logic                        req_overflow,
    output logic                        req_valid,
    input  logic                        req_ready,
    output logic                        protocol_error
);

    localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(MAX_WORDS);

    request_deser_state_t state_q;
    request_deser_state_t state_d;

    logic [WORD_W*MAX_WORDS-1:0] words_q;
    logic [COUNT_W-1:0]          count_q;
    logic                        overflow_q;
    logic                        perr_q;
    logic                        expire;

`ifdef REQUEST_DESERIALIZER_TIMEOUT_EN
    localparam int TIMER_W = count_width(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] timer_q;
    logic               timeout_q;

    // Terminal count reached on a cycle with no word: the partial request is
    // abandoned at this edge.
    assign expire = (state_q == ST_COLLECT) && !in_valid && (timer_q == '0);

    // Reloads outside COLLECT and on every accepted word, so entering COLLECT
    // always starts a full window.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            timer_q   <= TIMER_LOAD;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= expire;
            if ((state_q != ST_COLLECT) || in_valid) begin
                timer_q <= TIMER_LOAD;
            end else if (timer_q != '0) begin
                timer_q <= timer_q - TIMER_W'(1);
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = in_end_of_stream ? ST_PRESENT : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (in_valid && in_end_of_stream) begin
                    state_d = ST_PRESENT;
                end else if (expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (req_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode the registered state only, so waiting never depends
    // combinationally on the distributor's bus.
    always_comb begin
        waiting   = (state_q == ST_IDLE);
        req_valid = (state_q == ST_PRESENT);
    end

    // Word store and bundle metadata. Stale words above req_count are left in
    // place; the consumer only looks at the first req_count entries.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            words_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        words_q[0 +: WORD_W] <= in_data;
                        count_q              <= COUNT_W'(1);
                        overflow_q           <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (in_valid) begin
                        if (count_q == COUNT_FULL) begin
                            overflow_q <= 1'b1;
                        end else begin
                            words_q[int'(count_q)*WORD_W +: WORD_W] <= in_data;
                            count_q <= count_q + COUNT_W'(1);
                        end
                    end else if (expire) begin
                        count_q <= '0;
                    end
                end
                ST_PRESENT: begin
                    if (in_valid) begin
                        perr_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_words      = words_q;
    assign req_count      = count_q;
    assign req_overflow   = overflow_q;
    assign protocol_error = perr_q;

endmodule

// File: tb/tb_request_deserializer.sv
module tb_request_deserializer;

    localparam int MAXW = 4;
    localparam int CW   = $clog2(MAXW + 1);

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [31:0]          in_data;
    logic                 in_valid;
    logic                 in_end_of_stream;
    logic                 waiting;
    logic [32*MAXW-1:0]   req_words;
    logic [CW-1:0]        req_count;
    logic                 req_overflow;
    logic                 req_valid;
    logic                 req_ready;
    logic                 protocol_error;
`ifdef REQUEST_DESERIALIZER_TIMEOUT_EN
    logic                 timeout;
`endif

    request_deserializer #(
        .MAX_WORDS(MAXW)
`ifdef REQUEST_DESERIALIZER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_end_of_stream(in_end_of_stream),
        .waiting(waiting),
`ifdef REQUEST_DESERIALIZER_TIMEOUT_EN
        .timeout(timeout),
`endif
        .req_words(req_words),
        .req_count(req_count),
        .req_overflow(req_overflow),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .protocol_error(protocol_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [32*MAXW-1:0] w;
        logic [7:0]         cnt;
        logic               ovf;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] buf_words[0:15];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          ready_mode = 1;   // 0 random, 1 held low, 2 held high

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: a request of len words keeps the first min(len, MAXW) of them.
    function automatic exp_t model(input int len);
        exp_t e;
        int   keep;
        keep  = (len < MAXW) ? len : MAXW;
        e.w   = '0;
        e.cnt = 8'(keep);
        e.ovf = (len > MAXW);
        for (int k = 0; k < keep; k++) e.w[k*32 +: 32] = buf_words[k];
        return e;
    endfunction

    task automatic wait_idle();
        int t = 0;
        while (!waiting && t < 300) begin
            tick();
            t++;
        end
        check("wait_idle", {63'd0, waiting}, 64'd1);
    endtask

    task automatic send_req(input int len, input bit gaps);
        wait_idle();
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid         = 1'b0;
                in_data          = $urandom;
                in_end_of_stream = 1'($urandom_range(0, 1));
                tick();
            end
            in_valid         = 1'b1;
            in_data          = buf_words[i];
            in_end_of_stream = (i == len - 1);
            if (i == len - 1) exp_q.push_back(model(len));
            tick();
            if (i == 0) check("busy_after_first", {63'd0, waiting}, 64'd0);
        end
        in_valid         = 1'b0;
        in_end_of_stream = 1'b0;
        in_data          = $urandom;
        check("valid_latency", {63'd0, req_valid}, 64'd1);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       req_ready = ($urandom_range(0, 2) == 0);
                1:       req_ready = 1'b0;
                default: req_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops one expectation per presented bundle, then checks the
    // bundle stays put while valid and that waiting returns after acceptance.
    initial begin
        exp_t cur;
        bit   have_cur = 0;
        bit   acc_pend = 0;
        cur = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                have_cur = 0;
                acc_pend = 0;
            end else begin
                if (acc_pend) begin
                    check("waiting_after_accept", {63'd0, waiting}, 64'd1);
                    check("valid_drop_after_accept", {63'd0, req_valid}, 64'd0);
                    acc_pend = 0;
                    have_cur = 0;
                end
                if (req_valid) begin
                    if (!have_cur) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_valid", {63'd0, req_valid}, 64'd0);
                        end else begin
                            cur      = exp_q.pop_front();
                            have_cur = 1;
                        end
                    end
                    if (have_cur) begin
                        check("req_count", 64'(req_count), 64'(cur.cnt));
                        check("req_overflow", {63'd0, req_overflow}, {63'd0, cur.ovf});
                        check("waiting_in_present", {63'd0, waiting}, 64'd0);
                        for (int k = 0; k < int'(cur.cnt); k++)
                            check("req_word", 64'(req_words[k*32 +: 32]), 64'(cur.w[k*32 +: 32]));
                        if (req_ready) acc_pend = 1;
                    end
                end
            end
        end
    end

`ifdef REQUEST_DESERIALIZER_TIMEOUT_EN
    int n_timeout = 0;
    always @(negedge clock) if (timeout === 1'b1) n_timeout++;
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n          = 1'b0;
        in_valid         = 1'b0;
        in_data          = '0;
        in_end_of_stream = 1'b0;
        req_ready        = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("rst_waiting", {63'd0, waiting}, 64'd1);
        check("rst_valid", {63'd0, req_valid}, 64'd0);
        check("rst_count", 64'(req_count), 64'd0);
        check("rst_perr", {63'd0, protocol_error}, 64'd0);
        check("rst_ovf", {63'd0, req_overflow}, 64'd0);

        // Three words, held unaccepted, then released.
        ready_mode   = 1;
        buf_words[0] = 32'h11111111;
        buf_words[1] = 32'h22222222;
        buf_words[2] = 32'h33333333;
        send_req(3, 0);
        check("three_count", 64'(req_count), 64'd3);
        repeat (3) tick();
        check("held_waiting", {63'd0, waiting}, 64'd0);
        check("held_valid", {63'd0, req_valid}, 64'd1);
        ready_mode = 2;

        // Single word with end-of-stream straight from idle.
        buf_words[0] = 32'hDEADBEEF;
        wait_idle();
        ready_mode = 1;
        send_req(1, 0);
        check("single_count", 64'(req_count), 64'd1);
        check("single_ovf", {63'd0, req_overflow}, 64'd0);
        ready_mode = 2;

        // Six words into a four-word buffer.
        for (int i = 0; i < 6; i++) buf_words[i] = 32'hA0000000 + 32'(i);
        wait_idle();
        ready_mode = 1;
        send_req(6, 0);
        check("ovf_count", 64'(req_count), 64'd4);
        check("ovf_flag", {63'd0, req_overflow}, 64'd1);
        ready_mode = 2;

        // Randomized requests, lengths 1..7, with gaps and random ready.
        wait_idle();
        ready_mode = 0;
        for (int r = 0; r < 40; r++) begin
            int len;
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) buf_words[i] = $urandom;
            send_req(len, 1);
        end

        // Word arriving during presentation.
        ready_mode = 2;
        wait_idle();
        ready_mode = 1;
        for (int i = 0; i < 3; i++) buf_words[i] = $urandom;
        send_req(3, 0);
        tick();
        in_valid         = 1'b1;
        in_data          = 32'hBAD0BAD0;
        in_end_of_stream = 1'($urandom_range(0, 1));
        tick();
        in_valid         = 1'b0;
        in_end_of_stream = 1'b0;
        check("perr_set", {63'd0, protocol_error}, 64'd1);
        check("perr_still_valid", {63'd0, req_valid}, 64'd1);
        ready_mode = 2;
        wait_idle();
        repeat (5) tick();
        check("perr_sticky", {63'd0, protocol_error}, 64'd1);

        // Reset mid-collect discards the partial request.
        ready_mode = 0;
        wait_idle();
        in_valid         = 1'b1;
        in_end_of_stream = 1'b0;
        in_data          = $urandom;
        tick();
        in_data          = $urandom;
        tick();
        in_valid = 1'b0;
        check("collect_busy", {63'd0, waiting}, 64'd0);
        reset_n = 1'b0;
        tick();
        check("midrst_waiting", {63'd0, waiting}, 64'd1);
        check("midrst_valid", {63'd0, req_valid}, 64'd0);
        check("midrst_count", 64'(req_count), 64'd0);
        check("midrst_perr", {63'd0, protocol_error}, 64'd0);
        reset_n = 1'b1;
        repeat (5) tick();
        check("no_valid_after_rst", {63'd0, req_valid}, 64'd0);

`ifdef REQUEST_DESERIALIZER_TIMEOUT_EN
        begin
            int before;
            wait_idle();
            before           = n_timeout;
            in_valid         = 1'b1;
            in_end_of_stream = 1'b0;
            in_data          = $urandom;
            tick();
            in_data          = $urandom;
            tick();
            in_valid = 1'b0;
            repeat (20) tick();
            check("timeout_pulses", 64'(n_timeout - before), 64'd1);
            check("timeout_waiting", {63'd0, waiting}, 64'd1);
            check("timeout_count", 64'(req_count), 64'd0);
        end
`endif

        repeat (5) tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
